// File: rtl/smg_bin2seg.sv
// smg_bin2seg: Avalon-MM slave that turns a binary VALUE into six active-low
// 7-segment codes. Decimal mode uses a sequential double-dabble converter;
// hex mode encodes the nibbles directly. Supports leading-zero blanking,
// per-digit decimal points and a dash pattern on decimal overflow.
module smg_bin2seg #(
  parameter int VAL_W     = 24,
  parameter int SHIFT_CYC = 24
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic        avs_chipselect_n,
  input  logic        avs_address,
  input  logic [3:0]  avs_byteenable_n,
  input  logic        avs_write_n,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read_n,
  output logic [31:0] avs_readdata,
  output logic [47:0] coe_seg_data,
  output logic        coe_seg_valid,
  output logic        coe_busy
);

  localparam int CNT_W = $clog2(SHIFT_CYC + 1);
  localparam logic [VAL_W-1:0] DEC_MAX = VAL_W'(999_999);

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  // Host-visible registers
  logic [VAL_W-1:0] value_reg;
  logic             blz_reg;
  logic [5:0]       dp_reg;
  logic             hex_reg;
  logic             pending_reg;

  // Conversion datapath
  state_t           state_reg;
  logic [VAL_W-1:0] snap_reg;
  logic [VAL_W-1:0] shift_reg;
  logic [23:0]      bcd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             snap_blz_reg;
  logic [5:0]       snap_dp_reg;
  logic             snap_hex_reg;

  // Encoded result staged one cycle before it reaches the display bus
  logic [47:0]      enc_reg;
  logic             enc_valid_reg;

  logic             wr_en;
  logic             rd_en;
  logic [23:0]      bcd_adj;
  logic [47:0]      enc_next;
  logic [5:0]       digit_nz;
  logic             dec_ovf;
  logic             unused_wr;

  assign wr_en    = !avs_chipselect_n && !avs_write_n;
  assign rd_en    = !avs_chipselect_n && !avs_read_n;
  assign coe_busy = pending_reg || (state_reg != IDLE);
  assign dec_ovf  = !snap_hex_reg && (snap_reg > DEC_MAX);

  // Byte 3 of the bus carries nothing for either register
  assign unused_wr = ^{avs_writedata[31:24], avs_byteenable_n[3]};

  // Active-low segment pattern for one hex digit (dp bit left off)
  function automatic logic [7:0] seg7(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  // Per-digit logic: double-dabble add-3 correction and final segment encode
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      logic [3:0] nib;
      logic       show;
      logic [7:0] code;

      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];

      assign nib          = snap_hex_reg ? snap_reg[4*gi +: 4] : bcd_reg[4*gi +: 4];
      assign digit_nz[gi] = (nib != 4'd0);
      // Digit 0 always shows; higher digits need a nonzero digit at or above them
      assign show         = (gi == 0) || !snap_blz_reg || (|digit_nz[5:gi]);
      assign code         = dec_ovf ? 8'hBF : (show ? seg7(nib) : 8'hFF);
      assign enc_next[8*gi +: 8] = code & ~{snap_dp_reg[gi], 7'h00};
    end
  endgenerate

  // Combinational read mux; busy is exposed in CTRL bit 31
  always_comb begin
    avs_readdata = 32'h0;
    if (rd_en) begin
      if (avs_address)
        avs_readdata = {coe_busy, 14'h0, hex_reg, 2'b00, dp_reg, 7'h00, blz_reg};
      else
        avs_readdata = {8'h00, value_reg};
    end
  end

  // Byte-enabled register writes
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      value_reg <= '0;
      blz_reg   <= 1'b0;
      dp_reg    <= 6'h0;
      hex_reg   <= 1'b0;
    end else if (wr_en) begin
      if (!avs_address) begin
        if (!avs_byteenable_n[0]) value_reg[7:0]   <= avs_writedata[7:0];
        if (!avs_byteenable_n[1]) value_reg[15:8]  <= avs_writedata[15:8];
        if (!avs_byteenable_n[2]) value_reg[23:16] <= avs_writedata[23:16];
      end else begin
        if (!avs_byteenable_n[0]) blz_reg <= avs_writedata[0];
        if (!avs_byteenable_n[1]) dp_reg  <= avs_writedata[13:8];
        if (!avs_byteenable_n[2]) hex_reg <= avs_writedata[16];
      end
    end
  end

  // Conversion FSM; a write in the consuming cycle re-arms pending so no update is lost
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_reg     <= IDLE;
      pending_reg   <= 1'b0;
      snap_reg      <= '0;
      shift_reg     <= '0;
      bcd_reg       <= 24'h0;
      cnt_reg       <= '0;
      snap_blz_reg  <= 1'b0;
      snap_dp_reg   <= 6'h0;
      snap_hex_reg  <= 1'b0;
      enc_reg       <= 48'hFFFF_FFFF_FFFF;
      enc_valid_reg <= 1'b0;
    end else begin
      enc_valid_reg <= 1'b0;
      if (wr_en)
        pending_reg <= 1'b1;
      else if (state_reg == IDLE && pending_reg)
        pending_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (pending_reg) begin
            snap_reg     <= value_reg;
            shift_reg    <= value_reg;
            bcd_reg      <= 24'h0;
            cnt_reg      <= '0;
            snap_blz_reg <= blz_reg;
            snap_dp_reg  <= dp_reg;
            snap_hex_reg <= hex_reg;
            state_reg    <= hex_reg ? ENCODE : SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg   <= {bcd_adj[22:0], shift_reg[VAL_W-1]};
          shift_reg <= shift_reg << 1;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(SHIFT_CYC - 1))
            state_reg <= ENCODE;
        end
        ENCODE: begin
          enc_reg       <= enc_next;
          enc_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Display bus register: only whole, finished results are presented
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      coe_seg_data  <= 48'hFFFF_FFFF_FFFF;
      coe_seg_valid <= 1'b0;
    end else begin
      coe_seg_valid <= enc_valid_reg;
      if (enc_valid_reg)
        coe_seg_data <= enc_reg;
    end
  end

endmodule

// File: tb/tb_smg_bin2seg.sv
// tb_smg_bin2seg: randomized and directed bench for smg_bin2seg, checked
// against an arithmetic digit model (division/modulo, nibble extraction).
module tb_smg_bin2seg;

  logic        csi_clk = 1'b0;
  logic        csi_reset_n;
  logic        avs_chipselect_n;
  logic        avs_address;
  logic [3:0]  avs_byteenable_n;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic        avs_read_n;
  logic [31:0] avs_readdata;
  logic [47:0] coe_seg_data;
  logic        coe_seg_valid;
  logic        coe_busy;

  int checks   = 0;
  int failures = 0;

  // Reference register state
  logic [23:0] m_value;
  logic        m_blz;
  logic [5:0]  m_dp;
  logic        m_hex;

  logic [47:0] pulses [$];

  localparam logic [7:0] SEG_TBL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  smg_bin2seg dut (
    .csi_clk          (csi_clk),
    .csi_reset_n      (csi_reset_n),
    .avs_chipselect_n (avs_chipselect_n),
    .avs_address      (avs_address),
    .avs_byteenable_n (avs_byteenable_n),
    .avs_write_n      (avs_write_n),
    .avs_writedata    (avs_writedata),
    .avs_read_n       (avs_read_n),
    .avs_readdata     (avs_readdata),
    .coe_seg_data     (coe_seg_data),
    .coe_seg_valid    (coe_seg_valid),
    .coe_busy         (coe_busy)
  );

  always #5 csi_clk = ~csi_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected display word from the number itself, digit by digit
  function automatic logic [47:0] ref_seg(input logic [23:0] val, input logic blz,
                                          input logic [5:0] dp, input logic hex);
    int unsigned v = val;
    int unsigned d [6];
    int unsigned p = 1;
    int hi = 0;
    logic [7:0] code;
    logic [47:0] r = '0;
    for (int k = 0; k < 6; k++) begin
      d[k] = hex ? ((v >> (4 * k)) & 15) : ((v / p) % 10);
      p = p * 10;
      if (d[k] != 0) hi = k;
    end
    for (int k = 0; k < 6; k++) begin
      if (!hex && v > 999999) code = 8'hBF;
      else if (blz && k > hi)  code = 8'hFF;
      else                     code = SEG_TBL[d[k]];
      if (dp[k]) code = code & 8'h7F;
      r = {code, r[47:8]};
    end
    return r;
  endfunction

  function automatic logic [47:0] model_seg();
    return ref_seg(m_value, m_blz, m_dp, m_hex);
  endfunction

  task automatic av_write(input logic addr, input logic [31:0] data, input logic [3:0] be_n);
    @(negedge csi_clk);
    avs_chipselect_n = 1'b0;
    avs_write_n      = 1'b0;
    avs_address      = addr;
    avs_writedata    = data;
    avs_byteenable_n = be_n;
    @(posedge csi_clk);
    #1;
    avs_chipselect_n = 1'b1;
    avs_write_n      = 1'b1;
    avs_byteenable_n = 4'hF;
    if (!addr) begin
      if (!be_n[0]) m_value[7:0]   = data[7:0];
      if (!be_n[1]) m_value[15:8]  = data[15:8];
      if (!be_n[2]) m_value[23:16] = data[23:16];
    end else begin
      if (!be_n[0]) m_blz = data[0];
      if (!be_n[1]) m_dp  = data[13:8];
      if (!be_n[2]) m_hex = data[16];
    end
    $display("write addr=%0d data=%h be_n=%b -> value=%0d blz=%0d dp=%b hex=%0d",
             addr, data, be_n, m_value, m_blz, m_dp, m_hex);
  endtask

  task automatic av_read(input logic addr, output logic [31:0] d);
    @(negedge csi_clk);
    avs_chipselect_n = 1'b0;
    avs_read_n       = 1'b0;
    avs_address      = addr;
    #1;
    d = avs_readdata;
    avs_chipselect_n = 1'b1;
    avs_read_n       = 1'b1;
    #1;
    chk("rd_deselect", avs_readdata, 0);
    $display("read  addr=%0d data=%h", addr, d);
  endtask

  // Write, then wait for the single conversion it triggers and check it fully
  task automatic wr_conv(input logic addr, input logic [31:0] data, input logic [3:0] be_n);
    int lat = 0;
    int busy_cnt;
    bit got = 0;
    logic [47:0] exp_seg;
    av_write(addr, data, be_n);
    exp_seg  = model_seg();
    busy_cnt = coe_busy ? 1 : 0;
    while (lat < 100 && !got) begin
      @(posedge csi_clk);
      #1;
      lat++;
      if (coe_busy) busy_cnt++;
      if (coe_seg_valid) got = 1;
    end
    chk("valid_seen", got, 1);
    chk("latency", lat, m_hex ? 3 : 27);
    chk("busy_cycles", busy_cnt, m_hex ? 2 : 26);
    chk("seg_data", coe_seg_data, exp_seg);
    @(posedge csi_clk);
    #1;
    chk("valid_pulse_width", coe_seg_valid, 0);
    chk("seg_hold", coe_seg_data, exp_seg);
    $display("conv  value=%0d hex=%0d latency=%0d seg=%h", m_value, m_hex, lat, coe_seg_data);
  endtask

  task automatic monitor(input int n);
    repeat (n) begin
      @(posedge csi_clk);
      #1;
      if (coe_seg_valid) pulses.push_back(coe_seg_data);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [47:0] exp_a;
    logic [47:0] exp_b;
    logic [31:0] rv;
    logic [31:0] rdat;
    logic [3:0]  rbe;

    csi_reset_n      = 1'b0;
    avs_chipselect_n = 1'b1;
    avs_address      = 1'b0;
    avs_byteenable_n = 4'hF;
    avs_write_n      = 1'b1;
    avs_writedata    = 32'h0;
    avs_read_n       = 1'b1;
    m_value = '0; m_blz = 1'b0; m_dp = '0; m_hex = 1'b0;

    repeat (3) @(posedge csi_clk);
    #1;
    chk("rst_seg", coe_seg_data, 48'hFFFF_FFFF_FFFF);
    chk("rst_valid", coe_seg_valid, 0);
    chk("rst_busy", coe_busy, 0);
    @(negedge csi_clk);
    csi_reset_n = 1'b1;
    av_read(1'b0, rd); chk("rst_rd_value", rd, 0);
    av_read(1'b1, rd); chk("rst_rd_ctrl", rd, 0);

    // Directed scenarios with hand-derived patterns
    wr_conv(1'b0, 32'd123456, 4'h0);
    chk("dec_123456", coe_seg_data, 48'hF9A4_B099_9282);
    wr_conv(1'b1, 32'h1, 4'h0);
    wr_conv(1'b0, 32'd42, 4'h0);
    chk("blz_42", coe_seg_data, 48'hFFFF_FFFF_99A4);
    wr_conv(1'b0, 32'd0, 4'h0);
    chk("blz_zero", coe_seg_data, 48'hFFFF_FFFF_FFC0);
    wr_conv(1'b0, 32'd1000000, 4'h0);
    chk("overflow", coe_seg_data, 48'hBFBF_BFBF_BFBF);
    wr_conv(1'b0, 32'd999999, 4'h0);
    chk("max_dec", coe_seg_data, 48'h9090_9090_9090);
    wr_conv(1'b1, 32'h10000, 4'h0);
    wr_conv(1'b0, 32'hFFAB_CDEF, 4'h0);
    chk("hex_abcdef", coe_seg_data, 48'h8883_C6A1_868E);
    wr_conv(1'b1, 32'h0400, 4'h0);
    wr_conv(1'b0, 32'd123456, 4'h0);
    chk("dp_digit2", coe_seg_data, 48'hF9A4_B019_9282);
    wr_conv(1'b0, 32'h07, 4'b1110);
    av_read(1'b0, rd); chk("partial_wr", rd, 32'h0001_E207);
    av_read(1'b1, rd); chk("rd_ctrl", rd, 32'h0000_0400);

    // Back-to-back writes: second write lands mid-SHIFT
    wr_conv(1'b1, 32'h0, 4'h0);
    pulses.delete();
    av_write(1'b0, 32'd111111, 4'h0); exp_a = model_seg();
    monitor(5);
    av_write(1'b0, 32'd222222, 4'h0); exp_b = model_seg();
    monitor(80);
    chk("b2b_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      chk("b2b_first", pulses[0], exp_a);
      chk("b2b_second", pulses[1], exp_b);
    end

    // Several writes during a conversion collapse into one follow-up
    pulses.delete();
    av_write(1'b0, 32'd314159, 4'h0); exp_a = model_seg();
    monitor(3);
    av_write(1'b0, 32'd271828, 4'h0);
    monitor(3);
    av_write(1'b0, 32'd777, 4'h0); exp_b = model_seg();
    monitor(80);
    chk("collapse_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      chk("collapse_first", pulses[0], exp_a);
      chk("collapse_last", pulses[1], exp_b);
    end

    // Reset in the middle of SHIFT aborts everything
    av_write(1'b0, 32'd555555, 4'h0);
    monitor(10);
    @(negedge csi_clk);
    csi_reset_n = 1'b0;
    #1;
    chk("abort_seg", coe_seg_data, 48'hFFFF_FFFF_FFFF);
    chk("abort_valid", coe_seg_valid, 0);
    chk("abort_busy", coe_busy, 0);
    @(negedge csi_clk);
    csi_reset_n = 1'b1;
    m_value = '0; m_blz = 1'b0; m_dp = '0; m_hex = 1'b0;
    pulses.delete();
    monitor(40);
    chk("abort_no_pulse", pulses.size(), 0);
    av_read(1'b0, rd); chk("abort_rd_value", rd, 0);

    // Randomized conversions with register readback
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0: rv = $urandom_range(0, 99);
        1: rv = $urandom_range(0, 999999);
        2: rv = $urandom_range(999998, 1000001);
        default: rv = $urandom;
      endcase
      rbe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 3) == 0) begin
        rdat = $urandom;
        wr_conv(1'b1, rdat, rbe);
      end else begin
        wr_conv(1'b0, rv, rbe);
      end
      av_read(1'b0, rd); chk("rnd_rd_value", rd, {8'h00, m_value});
      av_read(1'b1, rd); chk("rnd_rd_ctrl", rd, {15'h0, m_hex, 2'b00, m_dp, 7'h00, m_blz});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
